// File: rtl/octet_job_arbiter.sv
// Round-robin owner selection for a shared Octet tensor-core tile, plus the
// start/fetch_done handshake, beat indexing, job_done return and a hang watchdog.
module octet_job_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned REQ_ID_W    = 2,
    parameter int unsigned FETCH_BEATS = 8,
    parameter int unsigned BEAT_W      = 3,
    parameter int unsigned WB_BEATS    = 8,
    parameter int unsigned WDOG_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic [REQ_ID_W-1:0] grant_id,
    output logic [NUM_REQ-1:0]  job_done,
    output logic                busy,
    output logic                octet_start,
    output logic                octet_fetch_done,
    input  logic                octet_idle,
    input  logic                octet_fetch,
    input  logic                octet_write_back,
    output logic                fetch_beat,
    output logic [BEAT_W-1:0]   fetch_idx,
    output logic                wb_beat,
    output logic [BEAT_W-1:0]   wb_idx,
    output logic                err_timeout
);

    localparam logic [BEAT_W-1:0]   FETCH_LAST = BEAT_W'(FETCH_BEATS - 1);
    localparam logic [BEAT_W-1:0]   WB_LAST    = BEAT_W'(WB_BEATS - 1);
    localparam logic [REQ_ID_W-1:0] LAST_ID    = REQ_ID_W'(NUM_REQ - 1);
    // Abort fires on the stalled cycle that would bring the watchdog to all-ones.
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = {WDOG_W{1'b1}} - WDOG_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_F,
        S_FETCH,
        S_FDONE,
        S_RUN,
        S_FIN
    } state_t;

    state_t              state;
    logic [REQ_ID_W-1:0] rr_ptr;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [WDOG_W-1:0]   wdog;

    logic                in_fetch;
    logic                fetch_hit;
    logic                wb_hit;
    logic                fin_hit;
    logic                stalled;
    logic                win_valid;
    logic [REQ_ID_W-1:0] win_id;
    logic [REQ_ID_W-1:0] cand;
    logic [REQ_ID_W-1:0] next_ptr;

    assign in_fetch  = (state == S_WAIT_F) || (state == S_FETCH);
    assign fetch_hit = in_fetch && octet_fetch;
    assign wb_hit    = (state == S_RUN) && octet_write_back;
    assign fin_hit   = (state == S_FIN) && octet_idle;

    // A cycle is "stalled" when the FSM neither changes state nor sees a beat.
    assign stalled = (in_fetch && !octet_fetch)
                  || ((state == S_RUN) && !octet_write_back)
                  || ((state == S_FIN) && !octet_idle);

    assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + REQ_ID_W'(1);

    // First set request at or after the pointer, wrapping.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        cand      = rr_ptr;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_id    = cand;
            end
            cand = (cand == LAST_ID) ? '0 : cand + REQ_ID_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            grant       <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            wdog        <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (win_valid && octet_idle) begin
                        grant    <= NUM_REQ'(1) << win_id;
                        grant_id <= win_id;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    beat_cnt <= '0;
                    state    <= S_WAIT_F;
                end
                S_WAIT_F: begin
                    if (octet_fetch) begin
                        beat_cnt <= BEAT_W'(1);
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (octet_fetch) begin
                        if (beat_cnt == FETCH_LAST) begin
                            beat_cnt <= '0;
                            state    <= S_FDONE;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                S_FDONE: begin
                    beat_cnt <= '0;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (octet_write_back) begin
                        if (beat_cnt == WB_LAST) begin
                            beat_cnt <= '0;
                            state    <= S_FIN;
                        end else begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                S_FIN: begin
                    if (octet_idle) begin
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: begin
                    grant    <= '0;
                    busy     <= 1'b0;
                    beat_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase

            // Watchdog: any progress clears it; a full stall window aborts the job.
            if (!busy || !stalled) begin
                wdog <= '0;
            end else if (wdog == WDOG_LAST) begin
                wdog        <= '0;
                err_timeout <= 1'b1;
                grant       <= '0;
                busy        <= 1'b0;
                beat_cnt    <= '0;
                rr_ptr      <= next_ptr;
                state       <= S_IDLE;
            end else begin
                wdog <= wdog + WDOG_W'(1);
            end
        end
    end

    assign octet_start      = (state == S_START);
    assign octet_fetch_done = (state == S_FDONE);
    assign fetch_beat       = fetch_hit;
    assign fetch_idx        = in_fetch ? beat_cnt : '0;
    assign wb_beat          = wb_hit;
    assign wb_idx           = (state == S_RUN) ? beat_cnt : '0;
    assign job_done         = fin_hit ? grant : '0;

endmodule

// File: tb/tb_octet_job_arbiter.sv
// Directed bench for octet_job_arbiter: single job, round robin, fetch stall,
// busy Octet, watchdog abort and reset mid-job.
module tb_octet_job_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic [3:0] job_done;
    logic       busy;
    logic       octet_start;
    logic       octet_fetch_done;
    logic       octet_idle;
    logic       octet_fetch;
    logic       octet_write_back;
    logic       fetch_beat;
    logic [2:0] fetch_idx;
    logic       wb_beat;
    logic [2:0] wb_idx;
    logic       err_timeout;

    int checks = 0;
    int passed = 0;

    octet_job_arbiter #(
        .NUM_REQ(4), .REQ_ID_W(2), .FETCH_BEATS(8), .BEAT_W(3), .WB_BEATS(8), .WDOG_W(4)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant), .grant_id(grant_id),
        .job_done(job_done), .busy(busy), .octet_start(octet_start),
        .octet_fetch_done(octet_fetch_done), .octet_idle(octet_idle),
        .octet_fetch(octet_fetch), .octet_write_back(octet_write_back),
        .fetch_beat(fetch_beat), .fetch_idx(fetch_idx), .wb_beat(wb_beat),
        .wb_idx(wb_idx), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running, expected to finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [21:0] all_outs();
        return {grant, grant_id, job_done, busy, octet_start, octet_fetch_done,
                fetch_beat, fetch_idx, wb_beat, wb_idx, err_timeout};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = '0;
        octet_idle = 1'b1;
        octet_fetch = 1'b0;
        octet_write_back = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (octet_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Octet write-back and return to idle, entered from the FDONE cycle.
    task automatic finish_job();
        tick(); octet_write_back = 1'b1;
        repeat (7) tick();
        tick(); octet_write_back = 1'b0; octet_idle = 1'b1;
        tick();
    endtask

    // Full Octet job, entered from the START cycle.
    task automatic handshake();
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1;
        repeat (7) tick();
        tick(); octet_fetch = 1'b0;
        finish_job();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        octet_idle = 1'b1;
        octet_fetch = 1'b0;
        octet_write_back = 1'b0;
        tick();
        checks++; if (all_outs() !== 22'd0) $display("FAIL reset_outputs: got %h expected 0", all_outs()); else passed++;
        rst = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_single_job();
        apply_reset();
        req = 4'b0010;
        #1;
        checks++; if ({grant, busy} !== 5'b0) $display("FAIL single_idle: got %b expected 00000", {grant, busy}); else passed++;
        tick(); #1;
        checks++; if (octet_start !== 1'b1) $display("FAIL single_start: got %b expected 1", octet_start); else passed++;
        checks++; if (grant !== 4'b0010) $display("FAIL single_grant: got %b expected 0010", grant); else passed++;
        checks++; if ({grant_id, busy} !== 3'b011) $display("FAIL single_id_busy: got %b expected 011", {grant_id, busy}); else passed++;
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1; #1;
        checks++; if ({octet_start, fetch_beat, fetch_idx} !== 5'b01000) $display("FAIL single_fetch0: got %b expected 01000", {octet_start, fetch_beat, fetch_idx}); else passed++;
        for (int k = 1; k < 8; k++) begin
            tick(); #1;
            checks++; if ({fetch_beat, fetch_idx} !== {1'b1, 3'(k)}) $display("FAIL single_fetch_idx%0d: got %b expected %b", k, {fetch_beat, fetch_idx}, {1'b1, 3'(k)}); else passed++;
        end
        tick(); octet_fetch = 1'b0; #1;
        checks++; if ({octet_fetch_done, fetch_beat} !== 2'b10) $display("FAIL single_fetch_done: got %b expected 10", {octet_fetch_done, fetch_beat}); else passed++;
        tick(); octet_write_back = 1'b1; #1;
        checks++; if ({octet_fetch_done, wb_beat, wb_idx} !== 5'b01000) $display("FAIL single_wb0: got %b expected 01000", {octet_fetch_done, wb_beat, wb_idx}); else passed++;
        for (int k = 1; k < 8; k++) begin
            tick(); #1;
            checks++; if ({wb_beat, wb_idx} !== {1'b1, 3'(k)}) $display("FAIL single_wb_idx%0d: got %b expected %b", k, {wb_beat, wb_idx}, {1'b1, 3'(k)}); else passed++;
        end
        tick(); octet_write_back = 1'b0; #1;
        checks++; if ({job_done, busy, wb_beat} !== 6'b000010) $display("FAIL single_fin_wait: got %b expected 000010", {job_done, busy, wb_beat}); else passed++;
        octet_idle = 1'b1; #1;
        checks++; if (job_done !== 4'b0010) $display("FAIL single_job_done: got %b expected 0010", job_done); else passed++;
        req = '0;
        tick(); #1;
        checks++; if ({grant, busy, job_done, err_timeout} !== 10'd0) $display("FAIL single_release: got %b expected 0", {grant, busy, job_done, err_timeout}); else passed++;
    endtask

    task automatic test_round_robin();
        bit seen;
        logic [1:0] exp_id;
        logic [3:0] exp_g;
        apply_reset();
        req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_start(seen);
            exp_id = 2'(j % 4);
            exp_g  = 4'b0001 << exp_id;
            checks++; if (seen !== 1'b1) $display("FAIL rr_start%0d: got %b expected 1", j, seen); else passed++;
            checks++; if ({grant, grant_id} !== {exp_g, exp_id}) $display("FAIL rr_grant%0d: got %b expected %b", j, {grant, grant_id}, {exp_g, exp_id}); else passed++;
            handshake();
        end
        req = '0;
        tick();
    endtask

    task automatic test_fetch_stall();
        bit seen;
        apply_reset();
        req = 4'b0001;
        wait_start(seen);
        checks++; if (seen !== 1'b1) $display("FAIL stall_start: got %b expected 1", seen); else passed++;
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if ({fetch_beat, fetch_idx} !== 4'b1011) $display("FAIL stall_beat3: got %b expected 1011", {fetch_beat, fetch_idx}); else passed++;
        for (int g = 0; g < 3; g++) begin
            tick(); octet_fetch = 1'b0; #1;
            checks++; if ({fetch_beat, octet_fetch_done, fetch_idx} !== 5'b00100) $display("FAIL stall_gap%0d: got %b expected 00100", g, {fetch_beat, octet_fetch_done, fetch_idx}); else passed++;
        end
        for (int k = 4; k < 8; k++) begin
            tick(); octet_fetch = 1'b1; #1;
            checks++; if ({fetch_beat, octet_fetch_done, fetch_idx} !== {2'b10, 3'(k)}) $display("FAIL stall_resume%0d: got %b expected %b", k, {fetch_beat, octet_fetch_done, fetch_idx}, {2'b10, 3'(k)}); else passed++;
        end
        tick(); octet_fetch = 1'b0; #1;
        checks++; if (octet_fetch_done !== 1'b1) $display("FAIL stall_fetch_done: got %b expected 1", octet_fetch_done); else passed++;
        req = '0;
        finish_job();
    endtask

    task automatic test_busy_octet();
        bit seen;
        apply_reset();
        octet_idle = 1'b0;
        req = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++; if ({grant, busy, octet_start} !== 6'b0) $display("FAIL busy_octet_hold%0d: got %b expected 000000", n, {grant, busy, octet_start}); else passed++;
            tick();
        end
        octet_idle = 1'b1;
        wait_start(seen);
        checks++; if ({seen, grant} !== 5'b10001) $display("FAIL busy_octet_grant: got %b expected 10001", {seen, grant}); else passed++;
        req = '0;
        handshake();
    endtask

    task automatic test_watchdog();
        bit seen;
        bit jd_seen;
        int n;
        apply_reset();
        req = 4'b0011;
        wait_start(seen);
        checks++; if ({seen, grant_id} !== 3'b100) $display("FAIL wdog_first_owner: got %b expected 100", {seen, grant_id}); else passed++;
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1;
        repeat (7) tick();
        tick(); octet_fetch = 1'b0; #1;
        checks++; if (octet_fetch_done !== 1'b1) $display("FAIL wdog_fdone: got %b expected 1", octet_fetch_done); else passed++;
        n = 0;
        jd_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick(); #1;
            n++;
            if (job_done !== 4'b0) jd_seen = 1'b1;
            if (busy !== 1'b1) break;
        end
        checks++; if (n !== 16) $display("FAIL wdog_abort_cycle: got %0d expected 16", n); else passed++;
        checks++; if ({err_timeout, busy, grant, jd_seen} !== 7'b1000000) $display("FAIL wdog_abort_state: got %b expected 1000000", {err_timeout, busy, grant, jd_seen}); else passed++;
        octet_idle = 1'b1;
        wait_start(seen);
        checks++; if ({seen, grant} !== 5'b10010) $display("FAIL wdog_next_owner: got %b expected 10010", {seen, grant}); else passed++;
        req = '0;
        handshake();
        checks++; if (err_timeout !== 1'b1) $display("FAIL wdog_sticky: got %b expected 1", err_timeout); else passed++;
    endtask

    task automatic test_reset_mid_fetch();
        bit seen;
        apply_reset();
        req = 4'b0100;
        wait_start(seen);
        checks++; if ({seen, grant_id} !== 3'b110) $display("FAIL rstmid_owner: got %b expected 110", {seen, grant_id}); else passed++;
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1;
        repeat (5) tick();
        #1;
        checks++; if ({fetch_beat, fetch_idx} !== 4'b1101) $display("FAIL rstmid_beat5: got %b expected 1101", {fetch_beat, fetch_idx}); else passed++;
        rst = 1'b1; #1;
        checks++; if (all_outs() !== 22'd0) $display("FAIL rstmid_async: got %h expected 0", all_outs()); else passed++;
        tick();
        checks++; if (all_outs() !== 22'd0) $display("FAIL rstmid_held: got %h expected 0", all_outs()); else passed++;
        rst = 1'b0;
        octet_fetch = 1'b0;
        octet_idle = 1'b1;
        req = 4'b1010;
        wait_start(seen);
        checks++; if ({seen, grant_id} !== 3'b101) $display("FAIL rstmid_ptr0: got %b expected 101", {seen, grant_id}); else passed++;
        octet_idle = 1'b0;
        tick(); octet_fetch = 1'b1; #1;
        checks++; if ({fetch_beat, fetch_idx} !== 4'b1000) $display("FAIL rstmid_restart_idx: got %b expected 1000", {fetch_beat, fetch_idx}); else passed++;
        req = '0;
        repeat (7) tick();
        tick(); octet_fetch = 1'b0;
        finish_job();
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_round_robin();
        test_fetch_stall();
        test_busy_octet();
        test_watchdog();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
